mc_dispatch: RTL and testbench

MC_DISPATCH -- requirements
Module: mc_dispatch

---
 rtl/mc_dispatch_if.sv | 35 +++
 rtl/mc_dispatch.sv | 125 ++++++++++++
 tb/tb_mc_dispatch.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_dispatch_if.sv
// Handshake bundle between the frame dispatcher, the Julia worker and the frame-buffer write port.
interface mc_dispatch_if #(
  parameter int WIDTH = 22
);
  logic                    frame_start;
  logic signed [WIDTH-1:0] c_real_in;
  logic signed [WIDTH-1:0] c_imag_in;
  logic signed [WIDTH-1:0] c_real_out;
  logic signed [WIDTH-1:0] c_imag_out;
  logic [9:0]              x;
  logic [9:0]              y;
  logic                    JW_start;
  logic                    MC_busy;
  logic                    JW_ready;
  logic                    JW_done;
  logic [7:0]              pixel;
  logic                    mem_write;
  logic [31:0]             mem_addr;
  logic [7:0]              mem_wdata;
  logic                    mem_wait;
  logic                    frame_busy;
  logic                    frame_done;

  modport master (
    input  frame_start, c_real_in, c_imag_in, JW_ready, JW_done, pixel, mem_wait,
    output c_real_out, c_imag_out, x, y, JW_start, MC_busy,
           mem_write, mem_addr, mem_wdata, frame_busy, frame_done
  );

  modport slave (
    output frame_start, c_real_in, c_imag_in, JW_ready, JW_done, pixel, mem_wait,
    input  c_real_out, c_imag_out, x, y, JW_start, MC_busy,
           mem_write, mem_addr, mem_wdata, frame_busy, frame_done
  );
endinterface

// File: rtl/mc_dispatch.sv
// Frame controller: walks every pixel row-major, hands each coordinate to the Julia worker
// and writes the returned byte into the frame buffer at OFFSET + y*H_RES + x.
module mc_dispatch #(
  parameter int          H_RES  = 640,
  parameter int          V_RES  = 480,
  parameter int          WIDTH  = 22,
  parameter logic [31:0] OFFSET = 32'h08000000
) (
  input  logic         clk,
  input  logic         n_rst,
  mc_dispatch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  state_t                  r_state;
  logic [9:0]              r_x;
  logic [9:0]              r_y;
  logic signed [WIDTH-1:0] r_c_real;
  logic signed [WIDTH-1:0] r_c_imag;
  logic                    r_jw_start;
  logic                    r_mc_busy;
  logic                    r_mem_write;
  logic [31:0]             r_mem_addr;
  logic [7:0]              r_mem_wdata;
  logic                    r_frame_busy;
  logic                    r_frame_done;
  logic [31:0]             w_addr;

  // Full 32-bit arithmetic so large frames never wrap the row product.
  assign w_addr = OFFSET + (32'(r_y) * 32'(H_RES)) + 32'(r_x);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_c_real     <= '0;
      r_c_imag     <= '0;
      r_jw_start   <= 1'b0;
      r_mc_busy    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_c_real     <= bus.c_real_in;
            r_c_imag     <= bus.c_imag_in;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_busy <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.JW_ready) begin
            r_jw_start <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_jw_start <= 1'b0;
          if (bus.JW_done) begin
            r_mem_wdata <= bus.pixel;
            r_mem_addr  <= w_addr;
            r_mem_write <= 1'b1;
            r_mc_busy   <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The write retires on the first edge that sees the memory not stalling.
          if (!bus.mem_wait) begin
            r_mem_write <= 1'b0;
            r_mc_busy   <= 1'b0;
            r_state     <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (r_x < X_LAST) begin
            r_x     <= r_x + 10'd1;
            r_state <= S_ISSUE;
          end else begin
            r_x <= '0;
            if (r_y < Y_LAST) begin
              r_y     <= r_y + 10'd1;
              r_state <= S_ISSUE;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          r_frame_busy <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.c_real_out = r_c_real;
  assign bus.c_imag_out = r_c_imag;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.JW_start   = r_jw_start;
  assign bus.MC_busy    = r_mc_busy;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.frame_busy = r_frame_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_mc_dispatch.sv
// Bench for mc_dispatch: a 4x2 frame instance with a behavioural worker and write scoreboard,
// plus a 640-wide instance exercising full-width row addressing up to 0x0804AFFF.
module tb_mc_dispatch;
  localparam int          W     = 22;
  localparam logic [31:0] OFF_A = 32'h08000000;
  localparam logic [31:0] OFF_B = 32'h0804AFFF - 32'd1279;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  mc_dispatch_if #(.WIDTH(W)) ifa ();
  mc_dispatch_if #(.WIDTH(W)) ifb ();

  mc_dispatch #(.H_RES(4), .V_RES(2), .WIDTH(W), .OFFSET(OFF_A)) dut_a (
    .clk(clk), .n_rst(rst_a), .bus(ifa)
  );
  mc_dispatch #(.H_RES(640), .V_RES(2), .WIDTH(W), .OFFSET(OFF_B)) dut_b (
    .clk(clk), .n_rst(rst_b), .bus(ifb)
  );

  int total = 0;
  int bad = 0;
  int done_a = 0;
  int wcnt_a = 0;
  int wcnt_b = 0;
  logic [31:0] last_b = '0;
  logic [39:0] sb[$];

  // Worker A: answers JW_start with pixel = x + 4y a few cycles later
  initial begin
    int cnt;
    cnt = 0;
    ifa.JW_done = 1'b0;
    ifa.pixel = 8'd0;
    forever begin
      @(negedge clk);
      ifa.JW_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ifa.JW_done = 1'b1;
          ifa.pixel = 8'(int'(ifa.x) + 4 * int'(ifa.y));
        end
      end
      if (ifa.JW_start) cnt = 2;
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    ifb.JW_done = 1'b0;
    ifb.pixel = 8'd0;
    forever begin
      @(negedge clk);
      ifb.JW_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ifb.JW_done = 1'b1;
          ifb.pixel = 8'(int'(ifb.x) + 4 * int'(ifb.y));
        end
      end
      if (ifb.JW_start) cnt = 2;
    end
  end

  // Scoreboard for instance A: every completed write is matched against the expected queue
  initial begin
    logic [39:0] exp;
    forever begin
      @(negedge clk);
      if (ifa.frame_done) done_a++;
      if (ifa.mem_write && !ifa.mem_wait) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%h data=%h, want no write", ifa.mem_addr, ifa.mem_wdata);
        end else begin
          exp = sb.pop_front();
          wcnt_a++;
          if ({ifa.mem_addr, ifa.mem_wdata} !== exp) begin
            bad++;
            $display("FAIL write_a: got addr=%h data=%h, want addr=%h data=%h",
                     ifa.mem_addr, ifa.mem_wdata, exp[39:8], exp[7:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (ifb.mem_write && !ifb.mem_wait) begin
        exp = OFF_B + 32'(wcnt_b);
        total++;
        if (ifb.mem_addr !== exp) begin
          bad++;
          $display("FAIL write_b: got addr=%h, want %h", ifb.mem_addr, exp);
        end
        last_b = ifb.mem_addr;
        wcnt_b++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame_a(input logic signed [W-1:0] cr, input logic signed [W-1:0] ci);
    for (int i = 0; i < 8; i++) sb.push_back({OFF_A + 32'(i), 8'(i)});
    ifa.c_real_in = cr;
    ifa.c_imag_in = ci;
    ifa.frame_start = 1'b1;
    tick();
    ifa.frame_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifa.frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [108:0] outs;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.frame_start = 1'b1;
    ifa.JW_ready = 1'b1;
    ifa.c_real_in = 22'sd55;
    repeat (3) tick();
    @(negedge clk);
    outs = {ifa.c_real_out, ifa.c_imag_out, ifa.x, ifa.y, ifa.JW_start, ifa.MC_busy,
            ifa.mem_write, ifa.mem_addr, ifa.mem_wdata, ifa.frame_busy, ifa.frame_done};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    ifa.frame_start = 1'b0;
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (ifa.frame_busy !== 1'b0 || ifa.JW_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b start=%b, want 0 0", ifa.frame_busy, ifa.JW_start);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int d0, w0;
    logic signed [W-1:0] cr, ci;
    cr = 22'sd12345;
    ci = -22'sd777;
    d0 = done_a;
    w0 = wcnt_a;
    ifa.JW_ready = 1'b1;
    ifa.mem_wait = 1'b0;
    tick();
    start_frame_a(cr, ci);
    wait_done_a(300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL frame_timeout: got no frame_done, want one");
    end
    total++;
    if (ifa.frame_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_at_done: got %b, want 1", ifa.frame_busy);
    end
    @(negedge clk);
    total++;
    if ({ifa.frame_done, ifa.frame_busy} !== 2'b00) begin
      bad++;
      $display("FAIL after_done: got done=%b busy=%b, want 0 0", ifa.frame_done, ifa.frame_busy);
    end
    total++;
    if (done_a - d0 != 1 || wcnt_a - w0 != 8 || sb.size() != 0) begin
      bad++;
      $display("FAIL frame_counts: got done=%0d writes=%0d left=%0d, want 1 8 0",
               done_a - d0, wcnt_a - w0, sb.size());
    end
    total++;
    if (ifa.c_real_out !== cr || ifa.c_imag_out !== ci) begin
      bad++;
      $display("FAIL c_latch: got %0d %0d, want %0d %0d", ifa.c_real_out, ifa.c_imag_out, cr, ci);
    end
    total++;
    if (ifa.x !== 10'd0 || ifa.y !== 10'd1) begin
      bad++;
      $display("FAIL xy_hold: got x=%0d y=%0d, want 0 1", ifa.x, ifa.y);
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    ifa.JW_ready = 1'b0;
    tick();
    start_frame_a(22'sd1, 22'sd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ifa.JW_start !== 1'b0 || ifa.x !== 10'd0 || ifa.y !== 10'd0) begin
        bad++;
        $display("FAIL ready_hold%0d: got start=%b x=%0d y=%0d, want 0 0 0", i, ifa.JW_start, ifa.x, ifa.y);
      end
    end
    tick();
    ifa.JW_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ifa.JW_start !== 1'b0) begin
      bad++;
      $display("FAIL start_early: got %b, want 0", ifa.JW_start);
    end
    @(negedge clk);
    total++;
    if (ifa.JW_start !== 1'b1) begin
      bad++;
      $display("FAIL start_pulse: got %b, want 1", ifa.JW_start);
    end
    @(negedge clk);
    total++;
    if (ifa.JW_start !== 1'b0) begin
      bad++;
      $display("FAIL start_width: got %b, want 0", ifa.JW_start);
    end
    wait_done_a(300, ok);
    @(negedge clk);
    total++;
    if (!ok || sb.size() != 0) begin
      bad++;
      $display("FAIL ready_frame: got done=%b left=%0d, want 1 0", ok, sb.size());
    end
  endtask

  task automatic test_mem_wait();
    bit ok, seen;
    int w0;
    w0 = wcnt_a;
    ifa.JW_ready = 1'b1;
    ifa.mem_wait = 1'b1;
    tick();
    start_frame_a(22'sd3, 22'sd4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifa.mem_write) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || ifa.mem_addr !== OFF_A || ifa.mem_wdata !== 8'd0 || ifa.MC_busy !== 1'b1) begin
      bad++;
      $display("FAIL wait_first: got seen=%b addr=%h data=%h busy=%b, want 1 %h 00 1",
               seen, ifa.mem_addr, ifa.mem_wdata, ifa.MC_busy, OFF_A);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      if (k == 4) ifa.mem_wait = 1'b0;
      @(negedge clk);
      total++;
      if ({ifa.mem_write, ifa.MC_busy, ifa.mem_addr, ifa.mem_wdata} !== {2'b11, OFF_A, 8'd0}) begin
        bad++;
        $display("FAIL wait_hold%0d: got wr=%b busy=%b addr=%h data=%h, want 1 1 %h 00",
                 k, ifa.mem_write, ifa.MC_busy, ifa.mem_addr, ifa.mem_wdata, OFF_A);
      end
    end
    @(negedge clk);
    total++;
    if (ifa.mem_write !== 1'b0 || ifa.MC_busy !== 1'b0 || wcnt_a - w0 != 1) begin
      bad++;
      $display("FAIL wait_release: got wr=%b busy=%b writes=%0d, want 0 0 1",
               ifa.mem_write, ifa.MC_busy, wcnt_a - w0);
    end
    wait_done_a(300, ok);
    @(negedge clk);
    total++;
    if (!ok || wcnt_a - w0 != 8 || sb.size() != 0) begin
      bad++;
      $display("FAIL wait_frame: got done=%b writes=%0d, want 1 8", ok, wcnt_a - w0);
    end
  endtask

  task automatic test_ignore_start();
    bit ok;
    int d0;
    d0 = done_a;
    ifa.JW_ready = 1'b1;
    ifa.mem_wait = 1'b0;
    tick();
    start_frame_a(22'sd100, 22'sd5);
    repeat (6) tick();
    ifa.c_real_in = -22'sd999;
    ifa.frame_start = 1'b1;
    tick();
    ifa.frame_start = 1'b0;
    @(negedge clk);
    total++;
    if (ifa.frame_busy !== 1'b1 || ifa.c_real_out !== 22'sd100) begin
      bad++;
      $display("FAIL ignore_mid: got busy=%b c_real=%0d, want 1 100", ifa.frame_busy, ifa.c_real_out);
    end
    wait_done_a(300, ok);
    repeat (10) @(negedge clk);
    total++;
    if (!ok || ifa.frame_busy !== 1'b0 || ifa.c_real_out !== 22'sd100 || done_a - d0 != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL ignore_after: got done=%b busy=%b c_real=%0d pulses=%0d, want 1 0 100 1",
               ok, ifa.frame_busy, ifa.c_real_out, done_a - d0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int d0;
    logic [108:0] outs;
    d0 = done_a;
    ifa.JW_ready = 1'b1;
    ifa.mem_wait = 1'b0;
    tick();
    start_frame_a(22'sd7, 22'sd8);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifa.JW_start && ifa.x == 10'd2 && ifa.y == 10'd1) begin
        seen = 1'b1;
        break;
      end
    end
    tick();
    ifa.mem_wait = 1'b1;
    for (int i = 0; i < 20 && seen; i++) begin
      @(negedge clk);
      if (ifa.mem_write) break;
    end
    total++;
    if (!seen || ifa.mem_write !== 1'b1 || ifa.mem_addr !== OFF_A + 32'd6) begin
      bad++;
      $display("FAIL mid_write: got seen=%b wr=%b addr=%h, want 1 1 %h", seen, ifa.mem_write, ifa.mem_addr, OFF_A + 32'd6);
    end
    tick();
    rst_a = 1'b1;
    tick();
    @(negedge clk);
    outs = {ifa.c_real_out, ifa.c_imag_out, ifa.x, ifa.y, ifa.JW_start, ifa.MC_busy,
            ifa.mem_write, ifa.mem_addr, ifa.mem_wdata, ifa.frame_busy, ifa.frame_done};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h, want 0", outs);
    end
    sb.delete();
    tick();
    rst_a = 1'b0;
    ifa.mem_wait = 1'b0;
    repeat (3) tick();
    total++;
    if (done_a != d0) begin
      bad++;
      $display("FAIL mid_no_done: got %0d pulses, want 0", done_a - d0);
    end
    start_frame_a(22'sd9, 22'sd10);
    @(negedge clk);
    total++;
    if (ifa.x !== 10'd0 || ifa.y !== 10'd0 || ifa.frame_busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_xy: got x=%0d y=%0d busy=%b, want 0 0 1", ifa.x, ifa.y, ifa.frame_busy);
    end
    wait_done_a(300, ok);
    @(negedge clk);
    total++;
    if (!ok || sb.size() != 0) begin
      bad++;
      $display("FAIL restart_frame: got done=%b left=%0d, want 1 0", ok, sb.size());
    end
  endtask

  task automatic test_default_addr();
    bit ok;
    ifb.JW_ready = 1'b1;
    ifb.mem_wait = 1'b0;
    ifb.c_real_in = 22'sd1;
    ifb.c_imag_in = 22'sd1;
    ifb.frame_start = 1'b1;
    tick();
    ifb.frame_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (ifb.frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || last_b !== 32'h0804AFFF || wcnt_b != 1280) begin
      bad++;
      $display("FAIL last_addr: got done=%b addr=%h writes=%0d, want 1 0804afff 1280", ok, last_b, wcnt_b);
    end
  endtask

  initial begin
    ifa.frame_start = 1'b0;
    ifa.c_real_in = '0;
    ifa.c_imag_in = '0;
    ifa.JW_ready = 1'b0;
    ifa.mem_wait = 1'b0;
    ifb.frame_start = 1'b0;
    ifb.c_real_in = '0;
    ifb.c_imag_in = '0;
    ifb.JW_ready = 1'b0;
    ifb.mem_wait = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    test_reset();
    test_frame();
    test_ready_stall();
    test_mem_wait();
    test_ignore_start();
    test_reset_mid();
    test_default_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
